// File: rtl/t03_dpu_pkg.sv
// Shared types and default raster constants for the sprite compositor pixel path.
package t03_dpu_pkg;

    localparam int COORD_W  = 11;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Width of the local row/column index handed to the sprite LUTs.
    localparam int SPR_IDX_W = 6;

    typedef logic [7:0]         rgb332_t;
    typedef logic [COORD_W-1:0] coord_t;

    localparam rgb332_t COLOR_BLACK = 8'h00;

endpackage

// File: rtl/t03_vga_timing.sv
// VGA raster counters, raw sync/active decode and the once-per-frame latch strobe.
// The strobe fires on the first pixel of the first blanking line so object
// registers are captured while nothing visible is being drawn.
module t03_vga_timing #(
    parameter int CNT_W    = 11,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             active,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             latch
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic h_wrap;

    assign h_wrap = (hcnt == H_LAST);

    // Raster position; vcnt steps once per line at the hcnt wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    assign active    = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hsync_raw = !((hcnt >= HS_BEG) && (hcnt < HS_END));
    assign vsync_raw = !((vcnt >= VS_BEG) && (vcnt < VS_END));
    assign latch     = pix_en && !rst && (hcnt == '0) && (vcnt == V_ACT);

endmodule

// File: rtl/t03_sprite_compositor.sv
// Sprite compositor: VGA timing, frame-latched object shadows, per-channel
// hit test and a 2-stage pixel pipeline driving RGB332 color and syncs.
// Optional build macro T03_COLLISION_EN adds per-channel sticky collision
// flags reported at each frame_start; without it collision is tied low.
module t03_sprite_compositor #(
    parameter int N_CH     = 2,
    parameter int COORD_W  = 11,
    parameter int SPR_W    = 40,
    parameter int SPR_H    = 60,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_en,
    input  logic [N_CH*COORD_W-1:0] obj_x,
    input  logic [N_CH*COORD_W-1:0] obj_y,
    input  logic [N_CH-1:0]         obj_en,
    input  logic [N_CH*8-1:0]       obj_color,
    input  logic [7:0]              bg_color,
    output logic [N_CH*6-1:0]       spr_row,
    output logic [N_CH*6-1:0]       spr_col,
    input  logic [N_CH-1:0]         spr_px,
    output logic [7:0]              color,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    frame_start,
    output logic [N_CH-1:0]         collision
);
    import t03_dpu_pkg::*;

    localparam int CW1 = COORD_W + 1;

    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    logic               active;
    logic               hsync_raw;
    logic               vsync_raw;
    logic               latch;

    t03_vga_timing #(
        .CNT_W    (COORD_W),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .active    (active),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .latch     (latch)
    );

    assign frame_start = latch;

    logic [N_CH*COORD_W-1:0] sh_x;
    logic [N_CH*COORD_W-1:0] sh_y;
    logic [N_CH-1:0]         sh_en;
    logic [N_CH*8-1:0]       sh_color;
    rgb332_t                 sh_bg;

    // Object shadows only change at the frame latch, so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_en    <= '0;
            sh_color <= '0;
            sh_bg    <= COLOR_BLACK;
        end else if (latch) begin
            sh_x     <= obj_x;
            sh_y     <= obj_y;
            sh_en    <= obj_en;
            sh_color <= obj_color;
            sh_bg    <= bg_color;
        end
    end

    // Stage 0: per-channel hit test. One extra bit keeps x+SPR_W from wrapping,
    // so sprites near the right/bottom edge are clipped instead of reappearing.
    logic [N_CH-1:0] hit;
    logic [CW1-1:0]  h_ext;
    logic [CW1-1:0]  v_ext;

    assign h_ext = {1'b0, hcnt};
    assign v_ext = {1'b0, vcnt};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [COORD_W-1:0] x_i;
        logic [COORD_W-1:0] y_i;
        logic [CW1-1:0]     x_lo;
        logic [CW1-1:0]     x_hi;
        logic [CW1-1:0]     y_lo;
        logic [CW1-1:0]     y_hi;

        assign x_i  = sh_x[i*COORD_W +: COORD_W];
        assign y_i  = sh_y[i*COORD_W +: COORD_W];
        assign x_lo = {1'b0, x_i};
        assign y_lo = {1'b0, y_i};
        assign x_hi = x_lo + CW1'(SPR_W);
        assign y_hi = y_lo + CW1'(SPR_H);

        assign hit[i] = sh_en[i]
                        && (h_ext >= x_lo) && (h_ext < x_hi)
                        && (v_ext >= y_lo) && (v_ext < y_hi);

        assign spr_col[i*SPR_IDX_W +: SPR_IDX_W] = hit[i] ? SPR_IDX_W'(hcnt - x_i) : '0;
        assign spr_row[i*SPR_IDX_W +: SPR_IDX_W] = hit[i] ? SPR_IDX_W'(vcnt - y_i) : '0;
    end

    logic [N_CH-1:0] s1_opaque;
    logic            s1_valid;
    logic            s1_active;
    logic            s1_hsync;
    logic            s1_vsync;

    // Stage 1: capture LUT opacity alongside the raw raster flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_opaque <= '0;
            s1_valid  <= 1'b0;
            s1_active <= 1'b0;
            s1_hsync  <= 1'b1;
            s1_vsync  <= 1'b1;
        end else if (pix_en) begin
            s1_opaque <= hit & spr_px;
            s1_valid  <= 1'b1;
            s1_active <= active;
            s1_hsync  <= hsync_raw;
            s1_vsync  <= vsync_raw;
        end
    end

    rgb332_t pick_color;

    // Lowest-index opaque channel wins; background shows through otherwise.
    always_comb begin
        pick_color = sh_bg;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (s1_opaque[i]) begin
                pick_color = sh_color[i*8 +: 8];
            end
        end
    end

    // Stage 2: pin registers; blanking forces black.
    always_ff @(posedge clk) begin
        if (rst) begin
            color <= COLOR_BLACK;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            color <= (s1_valid && s1_active) ? pick_color : COLOR_BLACK;
            hsync <= s1_hsync;
            vsync <= s1_vsync;
        end
    end

`ifdef T03_COLLISION_EN
    logic [N_CH-1:0] coll_flags;
    logic [N_CH-1:0] coll_new;

    assign coll_new = (s1_valid && ($countones(s1_opaque) > 1)) ? s1_opaque : '0;

    // Sticky flags per frame; the latch-cycle pixel seeds the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_flags <= '0;
            collision  <= '0;
        end else if (latch) begin
            collision  <= coll_flags;
            coll_flags <= coll_new;
        end else if (pix_en) begin
            coll_flags <= coll_flags | coll_new;
        end
    end
`else
    assign collision = '0;
`endif

endmodule
